legv8_multicycle_ctrl: RTL

Moore control FSM for the multicycle LEGv8 datapath. It replaces single-cycle decode with a per-instruction state sequence (fetch, decode, execute, memory, writeback) over one shared memory port. It uses a req/ready memory handshake with timeout, and has sticky fault reporting and a retired-instruction counter. It sits between the instruction register (opcode input) and the datapath enables/muxes.

---
 rtl/legv8_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: fetch/decode/execute/memory/writeback
// sequencing over one shared memory port with req/ready handshake.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode[10:0]        instr[31:21] from the IR (valid from DECODE on)
//   mem_ready           memory completion strobe (FETCH/MEMRD/MEMWR only)
//   pc_write, branch    PC+4 write / conditional branch-target write
//   ir_write, iord      IR load enable / address source (0=PC, 1=ALU)
//   mem_read, mem_write memory requests, held until mem_ready
//   reg2loc, alusrc_a,
//   alusrc_b, aluop,
//   memtoreg, reg_write datapath mux selects and register-file write
//   illegal, bus_err    sticky fault flags (held in their trap states)
//   state[3:0]          current state encoding
//   retired[CNT_W-1:0]  completed-instruction count (wraps)
module legv8_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             branch,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg2loc,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [1:0]       aluop,
    output logic             memtoreg,
    output logic             reg_write,
    output logic             illegal,
    output logic             bus_err,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_ADDR    = 4'd2,
        S_MEMRD   = 4'd3,
        S_LDWB    = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_CBZ     = 4'd8,
        S_ILLEGAL = 4'd9,
        S_BUSERR  = 4'd10
    } st_t;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;

    // Counter only needs to reach MEM_TIMEOUT-1.
    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    st_t           cur;
    logic [TW-1:0] cnt;
    logic          tmo;
    logic          is_ldur;
    logic          is_stur;
    logic          is_rtype;
    logic          is_cbz;

    assign is_ldur  = (opcode == OP_LDUR);
    assign is_stur  = (opcode == OP_STUR);
    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_ORR);
    // CBZ is 101_1010_0xxx: low three bits are don't-care.
    assign is_cbz   = (opcode[10:3] == 8'b1011_0100);

    // Timeout fires on the last allowed waiting cycle; a mem_ready in
    // that same cycle takes priority in the state update below.
    assign tmo = (MEM_TIMEOUT > 0) && (cnt == TW'(MEM_TIMEOUT - 1));

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_FETCH;
            cnt     <= '0;
            retired <= '0;
        end else begin
            // The counter is zero whenever a wait state is entered,
            // because every non-waiting cycle clears it.
            cnt <= '0;
            unique case (cur)
                S_FETCH: begin
                    if (mem_ready)
                        cur <= S_DECODE;
                    else if (tmo)
                        cur <= S_BUSERR;
                    else
                        cnt <= cnt + TW'(1);
                end
                S_DECODE: begin
                    if (is_ldur || is_stur)
                        cur <= S_ADDR;
                    else if (is_rtype)
                        cur <= S_REXEC;
                    else if (is_cbz)
                        cur <= S_CBZ;
                    else
                        cur <= S_ILLEGAL;
                end
                S_ADDR: begin
                    cur <= is_ldur ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready)
                        cur <= S_LDWB;
                    else if (tmo)
                        cur <= S_BUSERR;
                    else
                        cnt <= cnt + TW'(1);
                end
                S_LDWB: begin
                    cur     <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        cur     <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                    end else if (tmo) begin
                        cur <= S_BUSERR;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                S_REXEC: begin
                    cur <= S_RWB;
                end
                S_RWB: begin
                    cur     <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_CBZ: begin
                    cur     <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_ILLEGAL: begin
                    cur <= S_ILLEGAL;
                end
                S_BUSERR: begin
                    cur <= S_BUSERR;
                end
                default: begin
                    cur <= S_FETCH;
                end
            endcase
        end
    end

    // Outputs decode from the state register; only the fetch-cycle
    // IR/PC load depends on mem_ready, to complete zero-wait fetches.
    always_comb begin
        pc_write  = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg2loc   = 1'b0;
        alusrc_a  = 1'b0;
        alusrc_b  = 2'b00;
        aluop     = 2'b00;
        memtoreg  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        bus_err   = 1'b0;
        unique case (cur)
            S_FETCH: begin
                mem_read = 1'b1;
                alusrc_b = 2'b01;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                reg2loc = is_stur || is_cbz;
            end
            S_ADDR: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_LDWB: begin
                reg_write = 1'b1;
                memtoreg  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                reg2loc   = 1'b1;
            end
            S_REXEC: begin
                alusrc_a = 1'b1;
                aluop    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
            end
            S_CBZ: begin
                reg2loc  = 1'b1;
                alusrc_a = 1'b1;
                aluop    = 2'b01;
                branch   = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            S_BUSERR: begin
                bus_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
